// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the 9-bit core: PC, ROM address, registered word/valid.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_unit #(
    parameter int unsigned                PC_W      = 10,
    parameter int unsigned                INSTR_W   = 9,
    parameter logic [PC_W-1:0]            START_PC  = '0,
    parameter logic [INSTR_W-1:0]         HALT_WORD = '1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               instr_valid_o,
    output logic               done_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        cycle_cnt_o,
    output logic [15:0]        fetch_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 capture;
    logic                 start_accept;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0]          cycle_cnt_q, cycle_cnt_d;
    logic [15:0]          fetch_cnt_q, fetch_cnt_d;
`endif

    // Priority inside RUN: redirect, then stall, then halt detection, then capture.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        done_d       = done_q;
        capture      = 1'b0;
        start_accept = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_RUN;
                    fetch_pc_d   = START_PC;
                    start_accept = 1'b1;
                end
            end
            S_RUN: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    valid_d    = 1'b0;
                end else if (stall_i) begin
                    valid_d    = valid_q;
                end else if (imem_data_i == HALT_WORD) begin
                    state_d    = S_HALTED;
                    valid_d    = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    capture    = 1'b1;
                    instr_d    = imem_data_i;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 1'b1;
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
                if (start_i) begin
                    state_d      = S_RUN;
                    fetch_pc_d   = START_PC;
                    done_d       = 1'b0;
                    start_accept = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters saturate and only advance while running; HALTED leaves them frozen.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        if (start_accept) begin
            cycle_cnt_d = '0;
            fetch_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (cycle_cnt_q != 16'hFFFF) begin
                cycle_cnt_d = cycle_cnt_q + 16'd1;
            end
            if (capture && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= START_PC;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            cycle_cnt_q <= '0;
            fetch_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
`ifdef FETCH_PERF_CNT_EN
            cycle_cnt_q <= cycle_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
`endif
        end
    end

    assign imem_addr_o   = fetch_pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign done_o        = done_q;
`ifdef FETCH_PERF_CNT_EN
    assign cycle_cnt_o   = cycle_cnt_q;
    assign fetch_cnt_o   = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit with a behavioural async ROM.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       start_i, stall_i, redirect_i;
    logic [9:0] redirect_pc_i;
    logic [9:0] imem_addr_o;
    logic [8:0] imem_data_i;
    logic [8:0] instr_o;
    logic [9:0] pc_o;
    logic       instr_valid_o;
    logic       done_o;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_o, fetch_cnt_o;
`endif

    logic [8:0] rom [0:1023];

    typedef struct {
        logic       v;
        logic [9:0] pc;
        logic [8:0] instr;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instr_fetch_unit #(
        .PC_W     (10),
        .INSTR_W  (9),
        .START_PC (10'd0),
        .HALT_WORD(9'b111_111_111)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_valid_o(instr_valid_o),
        .done_o       (done_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .fetch_cnt_o  (fetch_cnt_o)
`endif
    );

    always #5 CLK = ~CLK;
    assign imem_data_i = rom[imem_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic v, input logic [9:0] pc, input logic [8:0] instr, input logic done);
        exp_t e;
        e.v = v; e.pc = pc; e.instr = instr; e.done = done;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the current DUT outputs.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(instr_valid_o), 32'(e.v));
            chk({tag, "_pc"},    32'(pc_o),          32'(e.pc));
            chk({tag, "_instr"}, 32'(instr_o),       32'(e.instr));
            chk({tag, "_done"},  32'(done_o),        32'(e.done));
        end
    endtask

    // Drive is already set; record expectation, advance one edge, compare.
    task automatic step(input string tag, input logic v, input logic [9:0] pc,
                        input logic [8:0] instr, input logic done);
        push(v, pc, instr, done);
        tick();
        sb_check(tag);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i % 256);
        rom[0] = 9'h041;
        rom[1] = 9'h082;
        rom[2] = 9'h0C3;
        rom[3] = 9'h1FF;

        RESET_N = 1'b0; start_i = 1'b0; stall_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        tick();
        step("reset", 1'b0, 10'd0, 9'h000, 1'b0);
        chk("reset_addr", 32'(imem_addr_o), 32'd0);
        RESET_N = 1'b1;

        // Basic program: start, three words, halt.
        start_i = 1'b1;
        step("start_edge", 1'b0, 10'd0, 9'h000, 1'b0);
        start_i = 1'b0;
        chk("start_addr", 32'(imem_addr_o), 32'd0);
        step("run_pc0", 1'b1, 10'd0, 9'h041, 1'b0);
        step("run_pc1", 1'b1, 10'd1, 9'h082, 1'b0);
        step("run_pc2", 1'b1, 10'd2, 9'h0C3, 1'b0);
        step("halt", 1'b0, 10'd2, 9'h0C3, 1'b1);
        chk("halt_addr", 32'(imem_addr_o), 32'd3);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", 32'(fetch_cnt_o), 32'd3);
        chk("perf_cycle", 32'(cycle_cnt_o), 32'd4);
`endif
        step("halted_hold", 1'b0, 10'd2, 9'h0C3, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_frozen", 32'(cycle_cnt_o), 32'd4);
`endif

        // Restart from HALTED, then stall while pc=1 is valid.
        start_i = 1'b1;
        step("restart", 1'b0, 10'd2, 9'h0C3, 1'b0);
        start_i = 1'b0;
        chk("restart_addr", 32'(imem_addr_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_clear", 32'(cycle_cnt_o), 32'd0);
`endif
        step("r_pc0", 1'b1, 10'd0, 9'h041, 1'b0);
        step("r_pc1", 1'b1, 10'd1, 9'h082, 1'b0);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("stall", 1'b1, 10'd1, 9'h082, 1'b0);
            chk("stall_addr", 32'(imem_addr_o), 32'd2);
        end
        stall_i = 1'b0;
        step("unstall_pc2", 1'b1, 10'd2, 9'h0C3, 1'b0);

        // Redirect with stall while the halt word is on the bus: redirect wins.
        chk("pre_redir_data", 32'(imem_data_i), 32'h1FF);
        redirect_i = 1'b1; redirect_pc_i = 10'd20; stall_i = 1'b1;
        step("redir_bubble", 1'b0, 10'd2, 9'h0C3, 1'b0);
        redirect_i = 1'b0; stall_i = 1'b0;
        chk("redir_addr", 32'(imem_addr_o), 32'd20);
        step("redir_target", 1'b1, 10'd20, 9'd20, 1'b0);

        // PC wrap at the top of the address space.
        redirect_i = 1'b1; redirect_pc_i = 10'h3FE;
        step("wrap_bubble", 1'b0, 10'd20, 9'd20, 1'b0);
        redirect_i = 1'b0;
        step("wrap_3fe", 1'b1, 10'h3FE, 9'hFE, 1'b0);
        step("wrap_3ff", 1'b1, 10'h3FF, 9'hFF, 1'b0);
        chk("wrap_addr", 32'(imem_addr_o), 32'd0);
        step("wrap_pc0", 1'b1, 10'd0, 9'h041, 1'b0);

        // Reset mid-run while valid is high.
        RESET_N = 1'b0;
        step("midrst", 1'b0, 10'd0, 9'h000, 1'b0);
        chk("midrst_addr", 32'(imem_addr_o), 32'd0);
        RESET_N = 1'b1;
        step("idle_hold", 1'b0, 10'd0, 9'h000, 1'b0);

        // Redirect and stall are ignored in IDLE.
        start_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 10'd50; stall_i = 1'b1;
        step("idle_start", 1'b0, 10'd0, 9'h000, 1'b0);
        start_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
        chk("idle_addr", 32'(imem_addr_o), 32'd0);
        step("i_pc0", 1'b1, 10'd0, 9'h041, 1'b0);
        step("i_pc1", 1'b1, 10'd1, 9'h082, 1'b0);
        step("i_pc2", 1'b1, 10'd2, 9'h0C3, 1'b0);
        step("i_halt", 1'b0, 10'd2, 9'h0C3, 1'b1);

        // start held high across HALTED->RUN must restart only once.
        start_i = 1'b1;
        step("hold_restart", 1'b0, 10'd2, 9'h0C3, 1'b0);
        step("hold_pc0", 1'b1, 10'd0, 9'h041, 1'b0);
        step("hold_pc1", 1'b1, 10'd1, 9'h082, 1'b0);
        start_i = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage that directly feeds the opcode decoder and ALU of the 9-bit core.
- Holds the PC and drives an asynchronous-read instruction ROM.
- Registers each fetched word with its PC and a valid flag, then hands it downstream.
- Handles downstream stall, branch redirect (from fnB0/fnB1 resolution) with a one-bubble flush, and start/halt program sequencing.

Parameters:
- PC_W, 10, PC and ROM address width; PC wraps modulo 2^PC_W.
- INSTR_W, 9, instruction width: opcode [8:6], function/operand [5:0].
- START_PC, 0, address loaded on reset and on every start.
- HALT_WORD, 9'b111_111_111, reserved encoding (opOTHER, fnB1, operand 3'b111) that terminates the program.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous reset, active low.
- start_i  in  1  begin execution at START_PC; sampled in IDLE/HALTED only.
- stall_i  in  1  downstream not ready; hold current output.
- redirect_i  in  1  taken branch resolved downstream; flush and refetch.
- redirect_pc_i  in  PC_W  branch target.
- imem_addr_o  out  PC_W  ROM address, equal to fetch_pc.
- imem_data_i  in  INSTR_W  ROM word at imem_addr_o, same cycle.
- instr_o  out  INSTR_W  registered instruction to decoder.
- pc_o  out  PC_W  address of instr_o.
- instr_valid_o  out  1  instr_o is a real, on-path instruction.
- done_o  out  1  program has halted; level.

Behaviour:
- Reset (RESET_N=0 at an edge): state=IDLE, fetch_pc=START_PC, instr_o=0, pc_o=0, instr_valid_o=0, done_o=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, HALTED. imem_addr_o is always fetch_pc (combinational from the register).
- IDLE:
  - start_i=1 → RUN. No capture on this edge.
  - stall_i and redirect_i are ignored.
- RUN, per edge, in priority order:
  1. redirect_i=1: fetch_pc<=redirect_pc_i; instr_valid_o<=0 (the wrong-path word is discarded); instr_o and pc_o hold. Redirect beats stall and halt detection in the same cycle.
  2. stall_i=1: all registers hold.
  3. imem_data_i==HALT_WORD: state<=HALTED; instr_valid_o<=0; done_o<=1; fetch_pc holds at the halt address. The halt word is never presented as valid.
  4. Otherwise: instr_o<=imem_data_i; pc_o<=fetch_pc; instr_valid_o<=1; fetch_pc<=fetch_pc+1 (mod 2^PC_W, so 2^PC_W-1 wraps to 0).
- Latency:
  - Word appears on instr_o one edge after its address is on imem_addr_o.
  - First valid instruction appears two edges after start_i is sampled.
  - Redirect costs exactly one invalid cycle; the target word is valid on the second edge after redirect.
- HALTED:
  - instr_valid_o=0; done_o=1 held.
  - start_i=1 → fetch_pc<=START_PC, done_o<=0, state RUN.
  - start_i during RUN is ignored.
- start_i is a level input. Holding it high across HALTED→RUN must not cause a double restart, because it is only sampled outside RUN.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add two outputs:
  - cycle_cnt_o [15:0]: increments every RUN cycle.
  - fetch_cnt_o [15:0]: increments on every rule-4 capture.
- Both counters clear on reset and on start_i accepted, saturate at 16'hFFFF, and freeze in HALTED.
- When undefined, both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, ROM[0..3]=9'h041,9'h082,9'h0C3,HALT_WORD; start_i one cycle → instr_valid_o high for pc_o=0,1,2 on consecutive cycles; done_o=1 the cycle after pc_o=2; instr_valid_o=0 thereafter.
- While pc_o=1 is valid, stall_i=1 for 3 cycles → instr_o, pc_o and imem_addr_o frozen for 3 cycles; pc_o=2 appears on the first unstalled edge.
- With pc_o=2 valid, redirect_i=1 with redirect_pc_i=10'd20 (same cycle also stall_i=1) → next cycle instr_valid_o=0; following cycle pc_o=20 valid with ROM[20].
- fetch_pc=10'h3FF with a non-halt word → pc_o=10'h3FF captured; next imem_addr_o=0.
- Redirect in the same cycle imem_data_i==HALT_WORD → no halt, done_o stays 0, target fetched; then start_i while HALTED → restarts at START_PC with done_o cleared.
- RESET_N=0 mid-run while instr_valid_o=1 → all outputs at reset values next edge; state IDLE. With FETCH_PERF_CNT_EN defined, after the 3-instruction program: fetch_cnt_o=3, cycle_cnt_o=4.
